// File: rtl/mix_round_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mix_round_sequencer                                                      |
// | Loads eight words from a seed, applies N mixing rounds, holds the result.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mix_round_sequencer #(
  parameter int MAX_ROUNDS = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_seed,
  input  logic [4:0]   in_rounds,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_data,
  output logic         busy,
  output logic [4:0]   rounds_left
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] c_max_rounds = 5'(MAX_ROUNDS);

  state_t       r_state;
  state_t       w_state_next;
  logic [255:0] r_words;
  logic [4:0]   r_rounds;
  logic         r_armed;
  logic         w_accept;
  logic [4:0]   w_load_rounds;

  function automatic logic [255:0] seed_words(input logic [31:0] seed);
    logic [255:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w[32*i +: 32] = seed + 32'(i);
    return w;
  endfunction

  // One round: add index, chained accumulate starting from o7, then xor-mix.
  function automatic logic [255:0] mix_round(input logic [255:0] s);
    logic [31:0]  a [8];
    logic [31:0]  b [8];
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) a[i] = s[32*i +: 32] + 32'(i);
    b[0] = a[0] + a[7];
    for (int i = 1; i < 8; i++) b[i] = a[i] + b[i-1];
    for (int i = 0; i < 8; i++) r[32*i +: 32] = b[i] ^ (b[(i + 3) % 8] << 16);
    return r;
  endfunction

  // r_armed keeps in_ready low until the first edge after reset release.
  assign in_ready      = r_armed & (r_state == IDLE) & ~abort;
  assign out_valid     = (r_state == DONE);
  assign busy          = (r_state != IDLE);
  assign out_data      = r_words;
  assign rounds_left   = r_rounds;
  assign w_accept      = in_valid & in_ready;
  assign w_load_rounds = (in_rounds > c_max_rounds) ? c_max_rounds : in_rounds;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_next = (w_load_rounds == 5'd0) ? DONE : RUN;
      RUN: begin
        if (abort)                   w_state_next = IDLE;
        else if (r_rounds == 5'd1)   w_state_next = DONE;
      end
      DONE: if (abort || out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_words  <= '0;
      r_rounds <= '0;
      r_armed  <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (w_accept) begin
        r_words  <= seed_words(in_seed);
        r_rounds <= w_load_rounds;
      end else if (r_state == RUN) begin
        if (abort) begin
          r_rounds <= '0;
        end else begin
          r_words  <= mix_round(r_words);
          r_rounds <= r_rounds - 5'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mix_round_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mix_round_sequencer                                                   |
// | Directed and randomized checks against a word-array reference model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mix_round_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_seed = '0;
  logic [4:0]   in_rounds = '0;
  logic         abort = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [255:0] out_data;
  logic         busy;
  logic [4:0]   rounds_left;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [255:0] c_r0_seed0 = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
  localparam logic [255:0] c_r1_seed0 = {32'h00140046, 32'h00100038, 32'h000E002C, 32'h00460022,
                                         32'h0038001A, 32'h002C0014, 32'h00220010, 32'h001A000E};

  mix_round_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_seed(in_seed), .in_rounds(in_rounds), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .rounds_left(rounds_left)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: words as plain integers; step B is a running sum seeded by o7.
  function automatic logic [255:0] ref_result(input logic [31:0] seed, input int rounds);
    int unsigned o [8];
    int unsigned t [8];
    int unsigned acc;
    int n;
    logic [255:0] res;
    n = (rounds > 31) ? 31 : rounds;
    for (int i = 0; i < 8; i++) o[i] = seed + i;
    for (int r = 0; r < n; r++) begin
      for (int i = 0; i < 8; i++) o[i] = o[i] + i;
      acc = o[7];
      for (int i = 0; i < 8; i++) begin
        acc  = acc + o[i];
        o[i] = acc;
      end
      for (int i = 0; i < 8; i++) t[i] = o[i] ^ (o[(i + 3) % 8] << 16);
      o = t;
    end
    for (int i = 0; i < 8; i++) res[32*i +: 32] = o[i];
    return res;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one job, wait for its result, check latency and data, then drain it.
  task automatic run_job(input logic [31:0] seed, input int rounds, output logic [255:0] got);
    int cyc;
    chk("job_in_ready", 256'(in_ready), 256'(1));
    in_valid  = 1'b1;
    in_seed   = seed;
    in_rounds = 5'(rounds);
    step();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
    chk("job_latency", 256'(cyc), 256'(rounds));
    chk("job_data", out_data, ref_result(seed, rounds));
    got = out_data;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("job_idle_busy", 256'(busy), 256'(0));
    chk("job_idle_in_ready", 256'(in_ready), 256'(1));
  endtask

  initial begin
    logic [255:0] got;
    logic [255:0] held;
    logic [255:0] exp_q [$];
    int accepts;
    int results;
    int guard;
    logic [31:0] s;

    // Reset state
    #2;
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    chk("rst_out_data", out_data, 256'(0));
    chk("rst_rounds_left", 256'(rounds_left), 256'(0));
    step();
    step();
    #2 rst = 1'b0;
    step();
    chk("post_rst_in_ready", 256'(in_ready), 256'(1));

    // Directed known-answer jobs
    run_job(32'd0, 0, got);
    chk("kat_r0", got, c_r0_seed0);
    run_job(32'd0, 1, got);
    chk("kat_r1", got, c_r1_seed0);
    run_job(32'hFFFF_FFFF, 31, got);

    // Randomized jobs
    for (int k = 0; k < 8; k++) begin
      run_job($urandom, $urandom_range(0, 31), got);
    end

    // Hold result with out_ready low
    s = $urandom;
    in_valid = 1'b1; in_seed = s; in_rounds = 5'd5;
    step();
    in_valid = 1'b0;
    chk("hold_rounds_left", 256'(rounds_left), 256'(5));
    repeat (5) step();
    for (int k = 0; k < 10; k++) begin
      chk("hold_out_valid", 256'(out_valid), 256'(1));
      chk("hold_out_data", out_data, ref_result(s, 5));
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hold_release_busy", 256'(busy), 256'(0));
    chk("hold_release_in_ready", 256'(in_ready), 256'(1));

    // Abort mid-run
    in_valid = 1'b1; in_seed = $urandom; in_rounds = 5'd8;
    step();
    in_valid = 1'b0;
    guard = 0;
    while (rounds_left != 5'd3 && guard < 20) begin
      chk("abort_no_valid_run", 256'(out_valid), 256'(0));
      step();
      guard++;
    end
    chk("abort_reached_3", 256'(rounds_left), 256'(3));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", 256'(busy), 256'(0));
    chk("abort_out_valid", 256'(out_valid), 256'(0));
    for (int k = 0; k < 5; k++) begin
      step();
      chk("abort_no_valid_after", 256'(out_valid), 256'(0));
    end

    // Abort in IDLE blocks acceptance and changes nothing
    held = out_data;
    abort = 1'b1; in_valid = 1'b1;
    #1;
    chk("idle_abort_in_ready", 256'(in_ready), 256'(0));
    step();
    chk("idle_abort_busy", 256'(busy), 256'(0));
    chk("idle_abort_data", out_data, held);
    abort = 1'b0; in_valid = 1'b0;
    #1;

    // Reset between edges in RUN
    in_valid = 1'b1; in_seed = $urandom; in_rounds = 5'd10;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    chk("pre_rst_busy", 256'(busy), 256'(1));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_data", out_data, 256'(0));
    chk("mid_rst_busy", 256'(busy), 256'(0));
    chk("mid_rst_out_valid", 256'(out_valid), 256'(0));
    chk("mid_rst_rounds_left", 256'(rounds_left), 256'(0));
    chk("mid_rst_in_ready", 256'(in_ready), 256'(0));
    step();
    #2 rst = 1'b0;
    step();
    run_job(32'd0, 1, got);
    chk("post_rst_kat_r1", got, c_r1_seed0);

    // in_valid held high across three rounds=2 jobs, consumer always ready
    accepts = 0;
    results = 0;
    in_rounds = 5'd2;
    in_seed = $urandom;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && results < 3; k++) begin
      #1;
      if (in_ready && busy) chk("b2b_accept_while_busy", 256'(1), 256'(0));
      if (out_valid) begin
        results++;
        chk("b2b_data", out_data, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        accepts++;
        exp_q.push_back(ref_result(in_seed, 2));
      end
      @(posedge clk);
      #1;
      if (accepts == 3) in_valid = 1'b0;
      in_seed = $urandom;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_accepts", 256'(accepts), 256'(3));
    chk("b2b_results", 256'(results), 256'(3));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
